// File: rtl/afp_acc16_pkg.sv
// Shared definitions for the binary16-alt accumulator: field widths,
// FSM state encoding, saturation value and a small zero-test helper.
package afp_acc16_pkg;

    localparam int DATA_W   = 16;
    localparam int COUNT_W  = 8;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 7;
    localparam int SIG_W    = FRAC_W + 1;   // significand including hidden one
    localparam int EXP_BIAS = 127;

    // Largest finite magnitude; the sign bit is supplied by the result.
    localparam logic [DATA_W-1:0] SAT_VAL = 16'h7F7F;

    typedef enum logic [2:0] {
        FSM_IDLE  = 3'd0,
        FSM_ALIGN = 3'd1,
        FSM_ADD   = 3'd2,
        FSM_NORM  = 3'd3,
        FSM_OUT   = 3'd4
    } fsm_state_e;

    // Plain vector constants so the state register stays a simple logic vector.
    localparam logic [2:0] ST_IDLE  = FSM_IDLE;
    localparam logic [2:0] ST_ALIGN = FSM_ALIGN;
    localparam logic [2:0] ST_ADD   = FSM_ADD;
    localparam logic [2:0] ST_NORM  = FSM_NORM;
    localparam logic [2:0] ST_OUT   = FSM_OUT;

    // An exponent field of zero means the value is zero, whatever the fraction.
    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return v[DATA_W-2 -: EXP_W] == '0;
    endfunction

endpackage

// File: rtl/afp_acc16_if.sv
// Term input stream and sum output stream of the accumulator.
interface afp_acc16_if import afp_acc16_pkg::*; ();

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [COUNT_W-1:0] out_count;
    logic               out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );

endinterface

// File: rtl/afp_lzc.sv
// Leading-zero counter for the adder result; an all-zero input returns W.
module afp_lzc #(
    parameter int W  = 12,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // seen[i] is set when any bit at or above position i is one
    logic [W-1:0] seen;

    assign seen[W-1] = value[W-1];

    genvar gi;
    generate
        for (gi = W - 2; gi >= 0; gi--) begin : g_seen
            assign seen[gi] = seen[gi+1] | value[gi];
        end
    endgenerate

    // Every position not yet covered by a one counts as a leading zero
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            if (!seen[i]) begin
                count = count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/afp_acc16.sv
// Sequential binary16-alt accumulator: one term per four cycles through
// ALIGN / ADD / NORM, sum presented in OUT after the term marked last.
module afp_acc16 import afp_acc16_pkg::*; #(
    parameter int GUARD = 3
) (
    input  logic           clk,
    input  logic           rst,
    afp_acc16_if.slave     bus
);

    localparam int         SW        = SIG_W + GUARD;     // aligned significand width
    localparam int         LZ_W      = $clog2(SW + 2);
    localparam logic [7:0] SHIFT_MAX = 8'(SW);

    logic [2:0]         state_reg;
    logic [DATA_W-1:0]  term_reg;
    logic               last_reg;
    logic [DATA_W-1:0]  acc_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               ovf_reg;

    // ALIGN results
    logic [SW-1:0]      a_sig_reg;
    logic [SW-1:0]      b_sig_reg;
    logic               a_sign_reg;
    logic               b_sign_reg;
    logic [EXP_W-1:0]   exp_reg;
    logic               byp_reg;
    logic [DATA_W-1:0]  byp_val_reg;

    // ADD results
    logic [SW:0]        sum_reg;
    logic               sum_sign_reg;

    // Combinational stage values
    logic [EXP_W-1:0]   acc_exp, term_exp, big_exp, exp_diff;
    logic [SW-1:0]      acc_sig, term_sig, big_sig, small_sig, small_al;
    logic               big_sign, small_sign;
    logic               byp_next;
    logic [DATA_W-1:0]  byp_val_next;
    logic [SW:0]        sum_next;
    logic               sum_sign_next;
    logic [LZ_W-1:0]    lz_count;
    logic [9:0]         shift_amt;
    logic [SW:0]        norm_shift;
    logic signed [9:0]  norm_exp;
    logic [FRAC_W-1:0]  norm_frac;
    logic [DATA_W-1:0]  norm_val;
    logic               norm_sat;
    logic               unused_norm;

    assign acc_exp  = acc_reg[DATA_W-2 -: EXP_W];
    assign term_exp = term_reg[DATA_W-2 -: EXP_W];
    assign acc_sig  = SW'({1'b1, acc_reg[FRAC_W-1:0]}) << GUARD;
    assign term_sig = SW'({1'b1, term_reg[FRAC_W-1:0]}) << GUARD;

    // Align the operand with the smaller exponent; a zero operand bypasses the math
    always_comb begin
        if (acc_exp >= term_exp) begin
            big_sig    = acc_sig;
            big_sign   = acc_reg[DATA_W-1];
            big_exp    = acc_exp;
            small_sig  = term_sig;
            small_sign = term_reg[DATA_W-1];
            exp_diff   = acc_exp - term_exp;
        end else begin
            big_sig    = term_sig;
            big_sign   = term_reg[DATA_W-1];
            big_exp    = term_exp;
            small_sig  = acc_sig;
            small_sign = acc_reg[DATA_W-1];
            exp_diff   = term_exp - acc_exp;
        end
        small_al = (exp_diff > SHIFT_MAX) ? '0 : (small_sig >> exp_diff);

        byp_next     = 1'b0;
        byp_val_next = acc_reg;
        if (is_zero(term_reg)) begin
            byp_next = 1'b1;
        end else if (is_zero(acc_reg)) begin
            byp_next     = 1'b1;
            byp_val_next = term_reg;
        end
    end

    // Signed-magnitude add; the larger magnitude decides the sign, exact cancel is +0
    always_comb begin
        sum_sign_next = a_sign_reg;
        if (a_sign_reg == b_sign_reg) begin
            sum_next = {1'b0, a_sig_reg} + {1'b0, b_sig_reg};
        end else if (a_sig_reg >= b_sig_reg) begin
            sum_next = {1'b0, a_sig_reg} - {1'b0, b_sig_reg};
        end else begin
            sum_next      = {1'b0, b_sig_reg} - {1'b0, a_sig_reg};
            sum_sign_next = b_sign_reg;
        end
        if (sum_next == '0) begin
            sum_sign_next = 1'b0;
        end
    end

    afp_lzc #(
        .W  (SW + 1),
        .CW (LZ_W)
    ) u_lzc (
        .value (sum_reg),
        .count (lz_count)
    );

    // Normalize, truncate to 7 fraction bits, then saturate or flush the exponent
    always_comb begin
        shift_amt  = 10'(lz_count) - 10'd1;
        norm_shift = sum_reg << shift_amt;
        norm_val   = '0;
        norm_sat   = 1'b0;
        if (sum_reg[SW]) begin
            norm_exp  = $signed({2'b00, exp_reg}) + 10'sd1;
            norm_frac = sum_reg[SW-1 -: FRAC_W];
        end else begin
            norm_exp  = $signed({2'b00, exp_reg}) - $signed(shift_amt);
            norm_frac = norm_shift[SW-2 -: FRAC_W];
        end

        if (byp_reg) begin
            norm_val = byp_val_reg;
        end else if (sum_reg == '0) begin
            norm_val = '0;
        end else if (norm_exp >= 10'sd255) begin
            norm_val = {sum_sign_reg, SAT_VAL[DATA_W-2:0]};
            norm_sat = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
            norm_val = '0;
        end else begin
            norm_val = {sum_sign_reg, norm_exp[EXP_W-1:0], norm_frac};
        end
    end

    // Only the fraction window of the shifted sum is meaningful
    assign unused_norm = ^norm_shift;

    // Datapath pipeline registers, loaded in the stage that produces them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sig_reg    <= '0;
            b_sig_reg    <= '0;
            a_sign_reg   <= 1'b0;
            b_sign_reg   <= 1'b0;
            exp_reg      <= '0;
            byp_reg      <= 1'b0;
            byp_val_reg  <= '0;
            sum_reg      <= '0;
            sum_sign_reg <= 1'b0;
        end else begin
            if (state_reg == ST_ALIGN) begin
                a_sig_reg   <= big_sig;
                b_sig_reg   <= small_al;
                a_sign_reg  <= big_sign;
                b_sign_reg  <= small_sign;
                exp_reg     <= big_exp;
                byp_reg     <= byp_next;
                byp_val_reg <= byp_val_next;
            end
            if (state_reg == ST_ADD) begin
                sum_reg      <= sum_next;
                sum_sign_reg <= sum_sign_next;
            end
        end
    end

    // Control FSM with term latch, running sum, term count and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            term_reg  <= '0;
            last_reg  <= 1'b0;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        term_reg  <= bus.in_data;
                        last_reg  <= bus.in_last;
                        if (count_reg != '1) begin
                            count_reg <= count_reg + 8'd1;
                        end
                        state_reg <= ST_ALIGN;
                    end
                end
                ST_ALIGN: state_reg <= ST_ADD;
                ST_ADD:   state_reg <= ST_NORM;
                ST_NORM: begin
                    acc_reg   <= norm_val;
                    ovf_reg   <= ovf_reg | norm_sat;
                    state_reg <= last_reg ? ST_OUT : ST_IDLE;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        acc_reg   <= '0;
                        count_reg <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = (state_reg == ST_OUT);
    assign bus.out_data  = acc_reg;
    assign bus.out_count = count_reg;
    assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_afp_acc16.sv
// Directed and randomized bench for afp_acc16 with an arithmetic reference model.
module tb_afp_acc16;

    localparam int G  = 3;
    localparam int SW = 8 + G;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_acc;
    int          model_cnt;
    bit          model_ovf;
    int          sum_no = 0;

    afp_acc16_if bus();

    afp_acc16 #(.GUARD(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: treat each operand as a scaled integer significand, shift the
    // smaller one down (truncating), add as signed integers, renormalize.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] t,
                                            output bit sat);
        int ea, et, e, ma, mt, s, mag, p, ne, frac;
        bit neg;
        logic [7:0] e8;
        logic [6:0] f7;
        sat = 1'b0;
        if (t[14:7] == 8'd0) return a;
        if (a[14:7] == 8'd0) return t;
        ea = int'(a[14:7]);
        et = int'(t[14:7]);
        ma = (128 + int'(a[6:0])) << G;
        mt = (128 + int'(t[6:0])) << G;
        e  = (ea > et) ? ea : et;
        ma = ((e - ea) > SW) ? 0 : (ma >> (e - ea));
        mt = ((e - et) > SW) ? 0 : (mt >> (e - et));
        s  = (a[15] ? -ma : ma) + (t[15] ? -mt : mt);
        if (s == 0) return 16'h0000;
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 24; i++) begin
            if (((mag >> i) & 1) != 0) p = i;
        end
        ne = e + p - (SW - 1);
        if (ne >= 255) begin
            sat = 1'b1;
            return {neg, 15'h7F7F};
        end
        if (ne <= 0) return 16'h0000;
        frac = (p >= 7) ? ((mag >> (p - 7)) & 127) : ((mag << (7 - p)) & 127);
        e8 = 8'(ne);
        f7 = 7'(frac);
        return {neg, e8, f7};
    endfunction

    function automatic logic [15:0] gen_term();
        int r;
        logic [7:0] e;
        r = $urandom_range(0, 9);
        case (r)
            0:       e = 8'd0;
            1:       e = 8'($urandom_range(250, 254));
            2:       e = 8'($urandom_range(1, 3));
            default: e = 8'($urandom_range(118, 135));
        endcase
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    task automatic model_clear();
        model_acc = 16'h0000;
        model_cnt = 0;
        model_ovf = 1'b0;
    endtask

    // Wait (bounded) for in_ready, then hand over one term; returns just after the edge
    task automatic accept(input logic [15:0] d, input logic l);
        int n;
        bit s;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_last  = 1'($urandom);
        if (model_cnt < 255) model_cnt++;
        model_acc = ref_add(model_acc, d, s);
        model_ovf = model_ovf | s;
    endtask

    // One full term: handshake plus three busy cycles with ignored in_valid noise
    task automatic send(input logic [15:0] d, input logic l);
        accept(d, l);
        bus.in_valid = 1'($urandom);
        @(negedge clk);
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called right after the fourth edge following the last handshake
    task automatic collect(input logic [15:0] ed, input int ec, input bit eo, input int hold);
        @(negedge clk);
        chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
        chk("out_data", 32'(bus.out_data), 32'(ed));
        chk("out_count", 32'(bus.out_count), 32'(ec));
        chk("out_ovf", 32'(bus.out_ovf), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(ed));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        $display("sum %0d: out_data=%h out_count=%0d out_ovf=%0b", sum_no, bus.out_data,
                 bus.out_count, bus.out_ovf);
        sum_no++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("after_out_valid", 32'(bus.out_valid), 32'd0);
        chk("after_out_in_ready", 32'(bus.in_ready), 32'd1);
        model_clear();
    endtask

    initial begin
        int n;
        logic [15:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        collect(16'h4040, 2, 1'b0, 0);

        // exact cancellation
        send(16'h3F80, 1'b0);
        send(16'hBF80, 1'b1);
        collect(16'h0000, 2, 1'b0, 0);

        // small term shifted out entirely
        send(16'h4B00, 1'b0);
        send(16'h3F80, 1'b1);
        collect(16'h4B00, 2, 1'b0, 0);

        // exponent saturation, then a clean single-term sum
        send(16'h7F00, 1'b0);
        send(16'h7F00, 1'b1);
        collect(16'h7F7F, 2, 1'b1, 0);
        send(16'h3F80, 1'b1);
        collect(16'h3F80, 1, 1'b0, 0);

        // consumer back-pressure for five cycles
        send(16'hC0A5, 1'b1);
        collect(16'hC0A5, 1, 1'b0, 5);

        // reset during ADD of the second term
        send(16'h3F80, 1'b0);
        accept(16'h4000, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_count", 32'(bus.out_count), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) n++;
        end
        chk("midrst_no_output", 32'(n), 32'd0);
        send(16'h4040, 1'b1);
        collect(16'h4040, 1, 1'b0, 0);

        // term count saturates at 255
        for (int k = 0; k < 256; k++) begin
            send({1'($urandom), 8'h00, 7'($urandom)}, (k == 255) ? 1'b1 : 1'b0);
        end
        collect(16'h0000, 255, 1'b0, 0);

        // randomized sums against the reference model
        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                d = gen_term();
                send(d, (k == n - 1) ? 1'b1 : 1'b0);
            end
            collect(model_acc, model_cnt, model_ovf, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
